// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one fixed-latency multiplier between two
// valid/ready requesters and returns each product to the requester that asked for it.
module mult_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 34
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_p,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_p,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    logic [1:0]         r_state;
    logic               r_last_grant;
    logic               r_owner;
    logic [7:0]         r_cnt;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [2*WIDTH-1:0] r_rsp_p;
    logic               r_rsp_valid;
    logic [15:0]        r_op_count;

    logic w_grant0;
    logic w_grant1;
    logic w_idle;
    logic w_accept;
    logic w_rsp_ready;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_grant0    = req0_valid && (!req1_valid || r_last_grant);
        w_grant1    = req1_valid && (!req0_valid || !r_last_grant);
        w_idle      = rst_n && (r_state == S_IDLE);
        w_accept    = w_idle && (w_grant0 || w_grant1);
        w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign rsp0_valid = r_rsp_valid && !r_owner;
    assign rsp1_valid = r_rsp_valid && r_owner;
    assign rsp0_p     = r_rsp_p;
    assign rsp1_p     = r_rsp_p;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign busy       = (r_state != S_IDLE);
    assign op_count   = r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_rsp_p      <= '0;
            r_rsp_valid  <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mul_a      <= w_grant1 ? req1_a : req0_a;
                        r_mul_b      <= w_grant1 ? req1_b : req0_b;
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_cnt        <= CNT_INIT;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Operands have now been stable for LATENCY cycles.
                    if (r_cnt == 8'd0) begin
                        r_rsp_p     <= mul_p;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a behavioural fixed-latency multiplier
// drives mul_p, and vectors plus hand sequences check arbitration and responses.
module tb_mult_share_arbiter;

    localparam int W = 32;
    localparam int L = 34;

    logic            clk;
    logic            rst_n;
    logic            req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [W-1:0]    req0_a, req0_b;
    logic [2*W-1:0]  rsp0_p;
    logic            req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]    req1_a, req1_b;
    logic [2*W-1:0]  rsp1_p;
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  mul_p;
    logic            busy;
    logic [15:0]     op_count;

    int        pass_cnt  = 0;
    int        total_cnt = 0;
    logic [15:0] exp_count = 16'd0;

    mult_share_arbiter #(.WIDTH(W), .LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product visible LATENCY edges after operands change.
    logic signed [2*W-1:0] pipe [0:L-2];
    always @(posedge clk) begin
        pipe[0] <= $signed(mul_a) * $signed(mul_b);
        for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_p = pipe[L-2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_req(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin req0_valid = v; req0_a = a; req0_b = b; end
        else         begin req1_valid = v; req1_a = a; req1_b = b; end
    endtask

    // Called just after the accept edge; returns just after the edge raising rsp valid.
    task automatic wait_valid(input int id, input logic [63:0] exp_p, input string tag);
        int   cyc = 0;
        logic other_seen = 1'b0;
        logic rdy_seen = 1'b0;
        logic got = 1'b0;
        while (cyc < 300 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if ((id == 0 ? rsp1_valid : rsp0_valid)) other_seen = 1'b1;
            if (req0_ready || req1_ready) rdy_seen = 1'b1;
            got = (id == 0) ? rsp0_valid : rsp1_valid;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(L));
        check({tag, "_product"}, (id == 0) ? rsp0_p : rsp1_p, exp_p);
        check({tag, "_other_valid"}, {63'd0, other_seen}, 64'd0);
        check({tag, "_ready_in_busy"}, {63'd0, rdy_seen}, 64'd0);
    endtask

    task automatic respond(input int id, input string tag);
        @(negedge clk);
        if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check({tag, "_valid_cleared"}, {63'd0, (id == 0) ? rsp0_valid : rsp1_valid}, 64'd0);
        check({tag, "_op_count"}, 64'(op_count), 64'(exp_count));
    endtask

    task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] exp_p, input string tag);
        @(negedge clk);
        drive_req(id, 1'b1, a, b);
        #1;
        check({tag, "_ready"}, {63'd0, (id == 0) ? req0_ready : req1_ready}, 64'd1);
        @(posedge clk); #1;
        drive_req(id, 1'b0, '0, '0);
        check({tag, "_mul_ab"}, {mul_a, mul_b}, {a, b});
        wait_valid(id, exp_p, tag);
        respond(id, tag);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        string       name;
    } vec_t;
    vec_t vecs [6];

    initial begin
        logic bad_v, bad_p, bad_r, flag;

        vecs[0] = '{0, 32'd5,          32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFE7, "v0_5x-5"};
        vecs[1] = '{1, 32'hFFFFFFFB,   32'hFFFFFFFB, 64'h0000000000000019, "v1_-5x-5"};
        vecs[2] = '{0, 32'd0,          32'hFFFFFFFB, 64'h0000000000000000, "v2_0x-5"};
        vecs[3] = '{0, 32'd1,          32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFFB, "v3_1x-5"};
        vecs[4] = '{0, 32'h80000000,   32'h80000000, 64'h4000000000000000, "v4_min_sq"};
        vecs[5] = '{1, 32'h7FFFFFFF,   32'h7FFFFFFF, 64'h3FFFFFFF00000001, "v5_max_sq"};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; rsp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        check("rst_rsp_valid", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        check("rst_rsp_p", rsp0_p, 64'd0);
        check("rst_busy_cnt", {47'd0, busy, op_count}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // Tie right after reset: requester 0 wins, then 1, then alternation.
        @(negedge clk);
        drive_req(0, 1'b1, 32'hFFFFFFF4, 32'd6);
        drive_req(1, 1'b1, 32'd8, 32'd6);
        #1;
        check("tie1_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        wait_valid(0, 64'hFFFFFFFFFFFFFFB8, "tie1_r0");
        respond(0, "tie1_r0");
        check("tie1_r1_grant", {62'd0, req0_ready, req1_ready}, 64'd1);
        @(posedge clk); #1;
        drive_req(1, 1'b0, '0, '0);
        wait_valid(1, 64'h30, "tie1_r1");
        respond(1, "tie1_r1");

        @(negedge clk);
        drive_req(0, 1'b1, 32'hFFFFFFF4, 32'd6);
        drive_req(1, 1'b1, 32'd8, 32'd6);
        #1;
        check("tie3_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
        @(posedge clk);
        wait_valid(0, 64'hFFFFFFFFFFFFFFB8, "tie3_r0");
        respond(0, "tie3_r0");
        check("tie4_grant_held", {62'd0, req0_ready, req1_ready}, 64'd1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        drive_req(1, 1'b0, '0, '0);
        wait_valid(1, 64'h30, "tie4_r1");
        respond(1, "tie4_r1");

        for (int i = 0; i < 6; i++)
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);

        // Response backpressure with the other requester waiting.
        @(negedge clk);
        drive_req(1, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFB);
        @(posedge clk); #1;
        drive_req(1, 1'b0, '0, '0);
        drive_req(0, 1'b1, 32'd3, 32'd7);
        wait_valid(1, 64'h19, "bp");
        bad_v = 1'b0; bad_p = 1'b0; bad_r = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!rsp1_valid || rsp0_valid || !busy) bad_v = 1'b1;
            if (rsp1_p !== 64'h19) bad_p = 1'b1;
            if (req0_ready || req1_ready) bad_r = 1'b1;
        end
        check("bp_valid_held", {63'd0, bad_v}, 64'd0);
        check("bp_p_stable", {63'd0, bad_p}, 64'd0);
        check("bp_no_accept", {63'd0, bad_r}, 64'd0);
        @(negedge clk); #1;
        check("bp_ready_at_resp", {63'd0, req0_ready}, 64'd0);
        respond(1, "bp");
        check("bp_next_ready", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        wait_valid(0, 64'd21, "bp_next");
        respond(0, "bp_next");

        // Reset in the middle of BUSY aborts the operation.
        @(negedge clk);
        drive_req(0, 1'b1, 32'd7, 32'd9);
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        repeat (L / 2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive_req(1, 1'b1, 32'd1, 32'd1);
        #1;
        exp_count = 16'd0;
        check("mid_rst_ready", {63'd0, req1_ready}, 64'd0);
        check("mid_rst_state", {46'd0, busy, rsp0_valid, op_count}, 64'd0);
        check("mid_rst_mul_ab", {mul_a, mul_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(1, 1'b0, '0, '0);
        flag = 1'b0;
        repeat (L + 4) begin
            @(posedge clk); #1;
            if (rsp0_valid || rsp1_valid || busy) flag = 1'b1;
        end
        check("mid_rst_no_rsp", {63'd0, flag}, 64'd0);
        do_op(0, 32'd2, 32'd3, 64'd6, "after_rst");

        // Operation counter wraps.
        @(negedge clk);
        force dut.r_op_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_op_count;
        #1;
        check("wrap_preload", 64'(op_count), 64'hFFFF);
        exp_count = 16'hFFFF;
        do_op(1, 32'd4, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, "wrap");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one signed 32x32 Booth multiplier datapath (`multOp_integration`-style: free-running on `clk`, no handshake, result valid a fixed number of cycles after operands are stable) between two requesters. It accepts one request at a time over valid/ready, holds operands stable for the multiplier's latency, and captures the 64-bit product. It returns the product to the originating requester over a valid/ready response channel. It sits between the two client blocks and the multiplier instance.

## Interface
- `WIDTH`, 32: operand width; product is 2*WIDTH.
- `LATENCY`, 34: cycles from operands stable at the multiplier input to `mul_p` valid; legal range 1..255.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_ready` out 1: requester 0 request accepted this cycle if `req0_valid`.
- `req0_a`, `req0_b` in WIDTH: requester 0 signed operands.
- `rsp0_valid` out 1: product for requester 0 available.
- `rsp0_ready` in 1: requester 0 takes product.
- `rsp0_p` out 2*WIDTH: signed product for requester 0.
- `req1_*`, `rsp1_*`: identical set for requester 1.
- `mul_a`, `mul_b` out WIDTH: registered operands to multiplier.
- `mul_p` in 2*WIDTH: multiplier product.
- `busy` out 1: high in BUSY or RESP.
- `op_count` out 16: completed operations (response handshakes), wraps 0xFFFF -> 0x0000.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset to IDLE.
- IDLE:
  - Grant is combinational. If exactly one `reqN_valid`, that N is granted. If both are valid, the requester other than `last_grant` is granted.
  - `reqN_ready` = (state==IDLE) && granted N. At most one ready is high per cycle.
  - On handshake: `mul_a`/`mul_b` <= request operands; `owner` <= N; `last_grant` <= N; counter <= LATENCY-1; go to BUSY.
- BUSY:
  - Counter decrements each cycle.
  - When the counter==0 on a rising edge: `rsp_p` register <= `mul_p`; `rsp<owner>_valid` <= 1; go to RESP.
- RESP:
  - `rsp<owner>_valid` stays high and `rsp<owner>_p` stays stable until `rsp<owner>_ready`.
  - On handshake: clear valid; `op_count` += 1; go to IDLE.
  - The non-owner `rspN_valid` is always 0.
- `rsp0_p` and `rsp1_p` both drive from the single result register. Only the valid qualifies it.
- `mul_a`/`mul_b` hold their last operands in IDLE and RESP. They change only on request acceptance.
- No new request is accepted in BUSY or RESP. Ready stays low there, even if a response handshake completes that cycle. The earliest next acceptance is the cycle after returning to IDLE.
- Arithmetic is performed by the multiplier. This block does no width conversion: `mul_p` is copied verbatim (two's complement, 2*WIDTH).

## Timing
- Reset values: `req0_ready`=`req1_ready`=0 while `rst_n` low; `rsp0_valid`=`rsp1_valid`=0; `rsp*_p`=0; `mul_a`=`mul_b`=0; `busy`=0; `op_count`=0; `last_grant`=1 (requester 0 wins the first tie).
- Request handshake at edge T: `mul_a`/`mul_b` are valid after T.
  - `mul_p` is sampled at edge T+LATENCY.
  - `rspN_valid` is high from edge T+LATENCY.
- Zero-wait response at edge T+LATENCY+1 gives IDLE; the next request is accepted at edge ≥ T+LATENCY+2. Peak throughput is one op per LATENCY+2 cycles.
- Reset asserted mid-operation: immediate abort, all outputs to reset values, no response issued, `op_count` cleared.
- Simultaneous valids in IDLE: grant alternates strictly. A requester dropping valid before grant is legal (no ready issued to it).
- Requester holding valid across a whole transaction: it is re-arbitrated in the next IDLE and loses a tie to the other requester.

## Test plan
- Req0 only, A=5, B=-5 (0xFFFFFFFB) → `rsp0_valid` exactly LATENCY cycles after accept, `rsp0_p`=0xFFFFFFFFFFFFFFE7 (-25), `op_count`=1, `rsp1_valid` never high.
- After reset, both valid in the same cycle: req0 -12×6, req1 8×6 → req0 served first with 0xFFFFFFFFFFFFFFB8 (-72), then req1 with 0x30 (48). A third tie goes to req0.
- Response backpressure: req1 -5×-5, hold `rsp1_ready`=0 for 10 cycles → `rsp1_valid` stays high, `rsp1_p`=0x19 stable, `req*_ready` low throughout, no new accept.
- Operand corner cases through one requester: 0×-5 → 0; 1×-5 → 0xFFFFFFFFFFFFFFFB; 0x80000000×0x80000000 → 0x4000000000000000.
- `rst_n` low at BUSY counter midpoint, then release → no response, all outputs at reset values, the next request completes normally.
- `op_count` preloaded by 65535 back-to-back ops (or a forced value of 0xFFFF) → the next completion wraps it to 0x0000.
